instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage between the program counter and decode. Each cycle it takes the current PC, issues a single-outstanding request to instruction memory and registers the returned word with its PC for decode. It handles variable memory latency, decode stalls through a one-entry skid buffer, and branch/jump flushes by discarding in-flight responses. A watchdog flags a memory that never answers.

## Interface
- TIMEOUT, 16: cycles a request may remain unanswered before `fetch_err` asserts; range 2–255.
- NOP, 32'h0000_0013: value of `instr_out` at reset and after a flush.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- pc_in  in  32  address to fetch, from the program counter.
- flush  in  1  redirect (jump or taken branch); `pc_in` holds the target from the following cycle.
- stall  in  1  decode/execute cannot accept a new instruction (load waiting on dmem).
- imem_rdata  in  32  instruction word returned by memory.
- imem_valid  in  1  `imem_rdata` is valid; meaningful only while `imem_req`=1.
- imem_req  out  1  request outstanding, registered.
- imem_addr  out  32  request address, registered, word-aligned.
- instr_out  out  32  instruction to decode.
- instr_pc  out  32  address of `instr_out`.
- instr_valid  out  1  `instr_out` is valid.
- pc_advance  out  1  combinational; the PC may step this cycle (response accepted and not flushed).
- fetch_err  out  1  sticky watchdog error; cleared only by reset.

## Operation
- FSM states: IDLE, WAIT, DROP.
- **Reset values:** state=IDLE, `imem_req`=0, `imem_addr`=0, `instr_out`=NOP, `instr_pc`=0, `instr_valid`=0, skid empty, `fetch_err`=0, watchdog=0.
- **IDLE:** if the skid is empty, go to WAIT with `imem_req`←1 and `imem_addr`←{`pc_in`[31:2],2'b00}.
- **WAIT:** `imem_req` and `imem_addr` are stable until `imem_valid`. On `imem_valid` without `flush`:
  - `pc_advance`=1.
  - If `stall`=0, the output register loads {rdata, addr} and `instr_valid`←1. Otherwise the skid loads {rdata, addr}.
  - If the skid will be empty, stay in WAIT and issue the next request back-to-back from `pc_in`. Otherwise go to IDLE with `imem_req`←0.
- **Flush has priority over the response and `stall`.**
  - In the flush cycle, `pc_advance`=0.
  - Next cycle: `instr_valid`=0, `instr_out`=NOP, skid emptied.
  - Flush in WAIT without `imem_valid` goes to DROP. Flush in WAIT with `imem_valid` in the same cycle discards that response and goes to IDLE.
  - Flush in IDLE stays in IDLE.
- **DROP:** `imem_req` stays 1. The response is discarded and the state goes to IDLE. A further `flush` in DROP stays in DROP.
- **Stall:** the output register holds while `stall`=1. When `stall` falls and the skid is full, the skid moves to the output register and the skid empties; the output register never loses a word.
- **instr_valid:** with `stall`=0 and no new word, `instr_valid`←0.
- **Watchdog:**
  - Counts cycles with `imem_req`=1 and `imem_valid`=0; clears on `imem_valid`.
  - Reaching TIMEOUT sets `fetch_err`.
  - The counter saturates at TIMEOUT and is 8 bits wide.
  - The request stays outstanding.
- `imem_addr` bits [1:0] are always 0. Misaligned `pc_in` is truncated, not trapped.

## Timing
- Zero-wait memory (`imem_valid` in the cycle `imem_req` is seen): one instruction per cycle. Response in cycle N gives `instr_valid` at N+1.
- First request goes out the cycle after reset deasserts (reset released at edge R → `imem_req`=1 after edge R+1).
- Flush to first valid new instruction, zero-wait memory, no outstanding DROP: 3 cycles. DROP adds the remaining latency of the dropped request.
- Asynchronous reset mid-request abandons the request immediately. Memory must tolerate `imem_req` dropping.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, WAIT, DROP}
  - NOP_INSTR constant
  - fetch packet typedef {instr[31:0], pc[31:0]}
- Optional sub-module `fetch_skid`: one-entry skid buffer holding a packet with a full flag and load/unload/clear. All other logic stays in the top.

## Test plan
1. **Zero-wait streaming.** Reset, PC increments 0,4,8; `imem_valid` held 1 returning 0xA0,0xA4,0xA8 → `instr_out` 0xA0/0xA4/0xA8 on consecutive cycles with `instr_pc` 0/4/8 and `pc_advance`=1 each cycle.
2. **Wait states.** `imem_valid` 3 cycles after `imem_req` for addr 0x10 → `imem_addr` stable at 0x10 for 3 cycles; `instr_valid` 1 for one cycle after the response; `pc_advance` pulses once.
3. **Stall with skid.** `stall`=1 for 4 cycles while `instr_out`=0xA4 and response 0xA8 arrives → `instr_out` holds 0xA4; `imem_req`=0 while skid full; 0xA8 appears the cycle after `stall` falls.
4. **Flush with in-flight response.** `flush` at addr 0x20 with a 2-cycle-latency response pending, target 0x100 → stale word never appears; `instr_valid`=0, `instr_out`=NOP; next request addr 0x100.
5. **Flush coincident with response.** `imem_valid` and `flush` in the same cycle → response dropped; `pc_advance`=0; IDLE next cycle.
6. **Watchdog.** TIMEOUT=4, `imem_valid` never asserted → `fetch_err` 1 after 4 waiting cycles and sticky; only `rst`=1 clears it, with all outputs back to reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch stage:
//                FSM state encoding, the canonical NOP word and the
//                {instr, pc} fetch packet.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch FSM states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Instruction word together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid
//  Description : One-entry skid buffer for a 64-bit fetch packet
//                ({instr, pc}). Catches a returned word while decode is
//                stalled so the output register never loses one.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                clear        - empty the buffer (highest priority)
//                load, in_pkt - capture in_pkt and mark full
//                unload       - mark empty (data consumed by the reader)
//                full, pkt    - occupancy flag and held packet
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        unload,
  input  logic [63:0] in_pkt,
  output logic        full,
  output logic [63:0] pkt
);

  logic        r_full;
  logic [63:0] r_data;

  // load and unload are never requested together by the fetch stage (load
  // needs a stall, unload needs no stall), so load simply wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (clear) begin
      r_full <= 1'b0;
    end else if (load) begin
      r_full <= 1'b1;
      r_data <= in_pkt;
    end else if (unload) begin
      r_full <= 1'b0;
    end
  end

  assign full = r_full;
  assign pkt  = r_data;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage. Issues single-outstanding requests
//                to instruction memory from pc_in, registers the returned
//                word with its address for decode, absorbs decode stalls in a
//                one-entry skid buffer, discards responses made stale by a
//                flush, and raises a sticky error when memory stops answering.
//  Ports       : clk, rst               - clock, asynchronous active-high reset
//                pc_in                  - address to fetch
//                flush                  - redirect; target on pc_in next cycle
//                stall                  - decode cannot accept a new word
//                imem_rdata, imem_valid - memory response
//                imem_req, imem_addr    - registered memory request
//                instr_out, instr_pc,
//                instr_valid            - packet presented to decode
//                pc_advance             - PC may step this cycle
//                fetch_err              - sticky watchdog error
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] NOP     = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        pc_advance,
  output logic        fetch_err
);

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

  fetch_state_t r_state;
  fetch_state_t w_state_next;

  logic        w_resp;
  logic        w_issue;
  logic        w_skid_full;
  logic        w_skid_load;
  logic        w_skid_unload;
  fetch_pkt_t  w_resp_pkt;
  fetch_pkt_t  w_skid_pkt;
  logic [7:0]  r_wd_cnt;
  logic [1:0]  w_unused_pc_lsb;

  // Misaligned PCs are silently truncated to a word boundary.
  assign w_unused_pc_lsb = pc_in[1:0];

  // In WAIT a request is always outstanding, so imem_valid alone qualifies it.
  assign w_resp     = (r_state == WAIT) && imem_valid;
  assign pc_advance = w_resp && !flush;
  assign w_resp_pkt = '{instr: imem_rdata, pc: imem_addr};

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (!flush && !w_skid_full) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          w_state_next = imem_valid ? IDLE : DROP;
        end else if (imem_valid && stall) begin
          // Word goes to the skid; hold off until decode drains it.
          w_state_next = IDLE;
        end
      end
      DROP: begin
        // The stale response retires the outstanding request even if another
        // flush lands in the same cycle; otherwise keep waiting for it.
        if (imem_valid) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Decide when a new request address is captured from pc_in.
  always_comb begin
    w_issue = 1'b0;
    unique case (r_state)
      IDLE:    w_issue = !flush && !w_skid_full;
      WAIT:    w_issue = pc_advance && !stall;   // back-to-back request
      default: w_issue = 1'b0;
    endcase
  end

  // ------------------------------------------------------------ request ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req  <= 1'b0;
      imem_addr <= 32'd0;
    end else begin
      imem_req <= (w_state_next != IDLE);
      if (w_issue) begin
        imem_addr <= {pc_in[31:2], 2'b00};
      end
    end
  end

  // --------------------------------------------------------------- skid ----
  assign w_skid_load   = pc_advance && stall;
  assign w_skid_unload = !flush && !stall && w_skid_full;

  fetch_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (w_skid_load),
    .unload (w_skid_unload),
    .in_pkt (w_resp_pkt),
    .full   (w_skid_full),
    .pkt    (w_skid_pkt)
  );

  // ---------------------------------------------------- output register ----
  // The skid always holds the older word, so it drains before a new response
  // could be taken (and while it is full no request is outstanding anyway).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out   <= NOP;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_out   <= NOP;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (w_skid_full) begin
        instr_out   <= w_skid_pkt.instr;
        instr_pc    <= w_skid_pkt.pc;
        instr_valid <= 1'b1;
      end else if (pc_advance) begin
        instr_out   <= w_resp_pkt.instr;
        instr_pc    <= w_resp_pkt.pc;
        instr_valid <= 1'b1;
      end else begin
        instr_valid <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------- watchdog ----
  // Saturating count of unanswered request cycles; the error is sticky and
  // the request itself is left outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt  <= 8'd0;
      fetch_err <= 1'b0;
    end else if (imem_req && !imem_valid) begin
      if (r_wd_cnt != C_TIMEOUT) begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end
      if (r_wd_cnt >= C_TIMEOUT - 8'd1) begin
        fetch_err <= 1'b1;
      end
    end else if (imem_req && imem_valid) begin
      r_wd_cnt <= 8'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Self-checking bench for instr_fetch. A transaction-level
//                reference model (output word, skid queue, outstanding
//                request, drop flag, watchdog count) predicts every output
//                each cycle; directed segments cover streaming, stall/skid,
//                flush cases and the watchdog, followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        flush;
  logic        stall;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        pc_advance;
  logic        fetch_err;

  instr_fetch #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .flush       (flush),
    .stall       (stall),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .pc_advance  (pc_advance),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------- reference model ----
  bit          m_req, m_drop, m_ov, m_err;
  logic [31:0] m_addr, m_instr, m_pc;
  fetch_pkt_t  m_skid[$];
  int          m_wd;

  // Environment: PC register and memory latency generator.
  logic [31:0] pc_reg;
  int          lat_left, min_lat, max_lat;
  bit          mem_dead;

  task automatic model_reset();
    m_req = 0; m_drop = 0; m_ov = 0; m_err = 0;
    m_addr = 32'd0; m_instr = NOP_INSTR; m_pc = 32'd0;
    m_skid.delete();
    m_wd = 0;
  endtask

  task automatic model_next(input bit fl, input bit st, input bit v,
                            input logic [31:0] rd, input logic [31:0] pc);
    bit resp, adv, skid_had;
    fetch_pkt_t p;
    resp     = m_req && v;
    adv      = resp && !m_drop && !fl;
    skid_had = (m_skid.size() != 0);

    if (m_req && !v) begin
      if (m_wd < TIMEOUT) m_wd++;
      if (m_wd >= TIMEOUT) m_err = 1;
    end else if (m_req && v) begin
      m_wd = 0;
    end

    if (fl) begin
      m_ov = 0; m_instr = NOP_INSTR; m_skid.delete();
    end else if (!st) begin
      if (skid_had) begin
        p = m_skid.pop_front(); m_instr = p.instr; m_pc = p.pc; m_ov = 1;
      end else if (adv) begin
        m_instr = rd; m_pc = m_addr; m_ov = 1;
      end else begin
        m_ov = 0;
      end
    end else if (adv) begin
      p.instr = rd; p.pc = m_addr; m_skid.push_back(p);
    end

    if (fl) begin
      if (resp) begin m_req = 0; m_drop = 0; end
      else if (m_req) m_drop = 1;
    end else if (m_drop) begin
      if (resp) begin m_req = 0; m_drop = 0; end
    end else if (m_req) begin
      if (resp) begin
        if (st) m_req = 0;
        else m_addr = pc & 32'hFFFF_FFFC;
      end
    end else if (!skid_had) begin
      m_req = 1; m_addr = pc & 32'hFFFF_FFFC;
    end
  endtask

  // One clock cycle: drive at negedge, compare, advance model, pass posedge.
  task automatic step(input bit fl, input bit st, input logic [31:0] tgt);
    bit adv;
    @(negedge clk);
    flush = fl; stall = st;
    imem_valid = 1'b0; imem_rdata = $urandom;
    if (imem_req && !mem_dead) begin
      if (lat_left == 0) begin
        imem_valid = 1'b1;
        imem_rdata = imem_addr + 32'hA0;
        lat_left   = $urandom_range(max_lat, min_lat);
      end else begin
        lat_left--;
      end
    end
    adv   = m_req && !m_drop && imem_valid && !fl;
    pc_in = (adv ? pc_reg + 32'd4 : pc_reg) | 32'($urandom_range(3, 0));
    #1;
    check_eq("imem_req",    32'(imem_req),    32'(m_req));
    check_eq("imem_addr",   imem_addr,        m_addr);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_ov));
    check_eq("instr_out",   instr_out,        m_instr);
    check_eq("instr_pc",    instr_pc,         m_pc);
    check_eq("fetch_err",   32'(fetch_err),   32'(m_err));
    check_eq("pc_advance",  32'(pc_advance),  32'(adv));
    model_next(fl, st, imem_valid, imem_rdata, pc_in);
    pc_reg = fl ? tgt : (adv ? pc_reg + 32'd4 : pc_reg);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; flush = 1'b0; stall = 1'b0; imem_valid = 1'b0;
    #1;
    check_eq("rst_imem_req",    32'(imem_req),    32'd0);
    check_eq("rst_imem_addr",   imem_addr,        32'd0);
    check_eq("rst_instr_out",   instr_out,        NOP_INSTR);
    check_eq("rst_instr_pc",    instr_pc,         32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_fetch_err",   32'(fetch_err),   32'd0);
    model_reset();
    pc_reg = 32'd0; pc_in = 32'd0; lat_left = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; imem_valid = 1'b0;
    imem_rdata = 32'd0; pc_in = 32'd0; mem_dead = 0;
    min_lat = 0; max_lat = 0;
    do_reset();

    // Zero-wait streaming: 0xA0/0xA4/0xA8 on consecutive cycles.
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("t1_instr0", instr_out, 32'hA0);
    check_eq("t1_pc0",    instr_pc,  32'h0);
    step(0, 0, 0);
    check_eq("t1_instr1", instr_out, 32'hA4);
    step(0, 0, 0);
    check_eq("t1_instr2", instr_out, 32'hA8);
    check_eq("t1_pc2",    instr_pc,  32'h8);

    // Stall for four cycles while 0xAC arrives into the skid.
    step(0, 1, 0);
    check_eq("t3_hold",    instr_out,      32'hA8);
    check_eq("t3_req_off", 32'(imem_req),  32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check_eq("t3_hold_end", instr_out,     32'hA8);
    check_eq("t3_req_end",  32'(imem_req), 32'd0);
    step(0, 0, 0);
    check_eq("t3_drain", instr_out, 32'hAC);
    check_eq("t3_pc",    instr_pc,  32'hC);
    step(0, 0, 0);
    check_eq("t3_next_addr", imem_addr, 32'h10);

    // Flush with a two-cycle-latency response in flight.
    min_lat = 2; max_lat = 2;
    step(0, 0, 0);
    step(1, 0, 32'h100);
    check_eq("t4_valid", 32'(instr_valid), 32'd0);
    check_eq("t4_nop",   instr_out,        NOP_INSTR);
    check_eq("t4_drop",  32'(imem_req),    32'd1);
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("t4_idle", 32'(imem_req), 32'd0);
    step(0, 0, 0);
    check_eq("t4_target", imem_addr, 32'h100);

    // Flush coincident with the response.
    min_lat = 0; max_lat = 0;
    for (int i = 0; i < 8 && lat_left != 0; i++) step(0, 0, 0);
    step(1, 0, 32'h200);
    check_eq("t5_req_off", 32'(imem_req),    32'd0);
    check_eq("t5_valid",   32'(instr_valid), 32'd0);

    // Random traffic.
    min_lat = 0; max_lat = TIMEOUT - 1;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(11, 0) == 0, $urandom_range(2, 0) == 0,
           $urandom & 32'h0000_FFFC);
    end

    // Watchdog: memory never answers.
    mem_dead = 1;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check_eq("t6_err_early", 32'(fetch_err), 32'd0);
    step(0, 0, 0);
    check_eq("t6_err_set", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    check_eq("t6_err_sticky", 32'(fetch_err), 32'd1);
    check_eq("t6_req_held",   32'(imem_req),  32'd1);
    do_reset();
    mem_dead = 0;
    for (int i = 0; i < 20; i++) step(0, $urandom_range(3, 0) == 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
